config_chain_loader: RTL and testbench

Serial configuration driver for the logic-tile configuration chain. It accepts the bitstream as parallel words over a valid/ready stream and shifts exactly CHAIN_LENGTH bits, MSB first, into a tile's serial config input, driving the chain's enable. At the same time it captures the bits leaving the chain's serial output and returns them as readback words. It sits between the bitstream source (host or ROM) and the config input of the first tile in the chain.

---
 rtl/config_chain_loader.sv | 105 ++++++++++
 tb/tb_config_chain_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// config_chain_loader: streams bitstream words MSB-first into a serial config chain while capturing its old contents as readback words.
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 146,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic [WORD_WIDTH-1:0] i_word_in,
  input  logic                  i_word_valid,
  output logic                  o_word_ready,
  output logic                  o_chain_data_out,
  output logic                  o_chain_enable,
  output logic                  o_chain_nreset,
  input  logic                  i_chain_data_in,
  output logic [WORD_WIDTH-1:0] o_readback_word,
  output logic                  o_readback_valid,
  input  logic                  i_readback_ready
);
  localparam int BW = $clog2(WORD_WIDTH + 1);
  localparam int TW = $clog2(CHAIN_LENGTH + 1);
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, FLUSH, DONE} state_t;
  state_t                r_state;
  logic [WORD_WIDTH-1:0] r_shift, r_readback;
  logic [BW-1:0]         r_bit;
  logic [TW-1:0]         r_total;
  logic                  r_busy, r_done, r_word_ready, r_data_out, r_enable, r_nreset, r_readback_valid;
  logic                  w_last_bit, w_last_word;
  logic [BW-1:0]         w_sh;
  logic [WORD_WIDTH-1:0] w_capture;
  // a word ends on a full word or on the final chain bit, whichever comes first
  assign w_last_bit  = (r_bit == BW'(WORD_WIDTH - 1)) || (r_total == TW'(CHAIN_LENGTH - 1));
  assign w_last_word = r_total == TW'(CHAIN_LENGTH);
  assign w_sh        = BW'(WORD_WIDTH - 1) - r_bit;
  assign w_capture   = {{(WORD_WIDTH-1){1'b0}}, i_chain_data_in} << w_sh;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= IDLE;
      r_shift          <= '0;
      r_readback       <= '0;
      r_bit            <= '0;
      r_total          <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_word_ready     <= 1'b0;
      r_data_out       <= 1'b0;
      r_enable         <= 1'b0;
      r_nreset         <= 1'b0;
      r_readback_valid <= 1'b0;
    end else begin
      r_nreset <= 1'b1;
      case (r_state)
        IDLE: if (i_start) begin
          r_state      <= FETCH;
          r_busy       <= 1'b1;
          r_word_ready <= 1'b1;
          r_total      <= '0;
        end
        FETCH: if (i_word_valid) begin
          r_state      <= SHIFT;
          r_word_ready <= 1'b0;
          r_enable     <= 1'b1;
          r_data_out   <= i_word_in[WORD_WIDTH-1];
          r_shift      <= {i_word_in[WORD_WIDTH-2:0], 1'b0};
          r_bit        <= '0;
          r_readback   <= '0;
        end
        SHIFT: begin
          r_total    <= r_total + 1'b1;
          r_bit      <= r_bit + 1'b1;
          r_readback <= r_readback | w_capture;
          r_data_out <= w_last_bit ? 1'b0 : r_shift[WORD_WIDTH-1];
          r_shift    <= {r_shift[WORD_WIDTH-2:0], 1'b0};
          if (w_last_bit) begin
            r_state          <= FLUSH;
            r_enable         <= 1'b0;
            r_readback_valid <= 1'b1;
          end
        end
        FLUSH: if (i_readback_ready) begin
          r_readback_valid <= 1'b0;
          r_state          <= w_last_word ? DONE : FETCH;
          r_done           <= w_last_word;
          r_word_ready     <= !w_last_word;
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_word_ready     = r_word_ready;
  assign o_chain_data_out = r_data_out;
  assign o_chain_enable   = r_enable;
  assign o_chain_nreset   = r_nreset;
  assign o_readback_word  = r_readback;
  assign o_readback_valid = r_readback_valid;
endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: table-driven loads against a behavioural chain model with a readback scoreboard.
module tb_config_chain_loader;
  localparam int CL = 146, W = 32, NW = 5;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, wv = 1'b0, rr = 1'b0;
  logic [W-1:0] win = '0;
  logic busy, done, wr, cdo, cen, cnr, cdi, rbv;
  logic [W-1:0] rbw;
  logic [CL-1:0] chain, pre_val = '0;
  logic pre_load = 1'b0;
  logic start2 = 1'b0, wv2 = 1'b0, rr2 = 1'b0, pre2 = 1'b0;
  logic [W-1:0] win2 = '0;
  logic busy2, done2, wr2, cdo2, cen2, cnr2, cdi2, rbv2;
  logic [W-1:0] rbw2;
  logic [63:0] chain2, pre_val2 = '0;
  int checks = 0, fails = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] rb_got[NW], rb_prev[NW];
  logic [CL-1:0] chain_prev;

  typedef struct {
    logic [NW-1:0][W-1:0] words;
    int pre, vs_w, vs_n, rs_w, rs_n, start_at, abort_at, exp_en, exp_rb, exp_done;
  } vec_t;

  always #5 clk = ~clk;

  config_chain_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(W)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .i_word_in(win), .i_word_valid(wv), .o_word_ready(wr), .o_chain_data_out(cdo),
    .o_chain_enable(cen), .o_chain_nreset(cnr), .i_chain_data_in(cdi),
    .o_readback_word(rbw), .o_readback_valid(rbv), .i_readback_ready(rr));

  config_chain_loader #(.CHAIN_LENGTH(64), .WORD_WIDTH(W)) u_dut64 (
    .i_clock(clk), .i_reset(rst), .i_start(start2), .o_busy(busy2), .o_done(done2),
    .i_word_in(win2), .i_word_valid(wv2), .o_word_ready(wr2), .o_chain_data_out(cdo2),
    .o_chain_enable(cen2), .o_chain_nreset(cnr2), .i_chain_data_in(cdi2),
    .o_readback_word(rbw2), .o_readback_valid(rbv2), .i_readback_ready(rr2));

  // behavioural chains: position 0 is the first stage, the top position feeds back
  always @(posedge clk) begin
    if (pre_load) chain <= pre_val;
    else if (cen) chain <= {chain[CL-2:0], cdo};
    if (pre2) chain2 <= pre_val2;
    else if (cen2) chain2 <= {chain2[62:0], cdo2};
  end
  assign cdi  = chain[CL-1];
  assign cdi2 = chain2[63];

  task automatic chk(input string name, input logic [CL-1:0] act, input logic [CL-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int pre, vs_w, vs_n, rs_w, rs_n, start_at, abort_at, exp_en, exp_rb, exp_done);
    vec_t v;
    v.words = '0;
    v.pre = pre; v.vs_w = vs_w; v.vs_n = vs_n; v.rs_w = rs_w; v.rs_n = rs_n;
    v.start_at = start_at; v.abort_at = abort_at;
    v.exp_en = exp_en; v.exp_rb = exp_rb; v.exp_done = exp_done;
    return v;
  endfunction

  task automatic run_vec(input int id, input vec_t v);
    logic [CL-1:0] exp_chain;
    logic [W-1:0] rw;
    int wi = 0, ri = 0, en = 0, dn = 0, vc = 0, rc = 0;
    bit fin = 0, bad_gap = 0;
    if (v.pre == 1) for (int p = 0; p < CL; p++) pre_val[p] = ((CL - 1 - p) % 2 == 0);
    if (v.pre == 2) for (int p = 0; p < CL; p++) pre_val[p] = 1'($urandom);
    if (v.pre != 0) begin
      pre_load = 1'b1; @(posedge clk); #1; pre_load = 1'b0;
    end
    sb.delete();
    for (int i = 0; i < NW; i++) begin
      rw = '0;
      for (int j = 0; j < W; j++) if (i * W + j < CL) rw[W-1-j] = chain[CL-1-(i*W+j)];
      sb.push_back(rw);
    end
    for (int k = 0; k < CL; k++) exp_chain[CL-1-k] = v.words[k/W][W-1-(k%W)];
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    chk($sformatf("v%0d_busy_ready_after_start", id), {busy, wr}, 2'b11);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (cen) en++;
      if (done) dn++;
      if (cen && (wr || rbv)) bad_gap = 1;
      if (v.abort_at != 0 && cen && en == v.abort_at) begin
        rst = 1'b1; wv = 1'b0; rr = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        chk($sformatf("v%0d_abort_outputs", id), {busy, done, wr, cdo, cen, cnr, rbv, rbw}, '0);
        sb.delete();
        fin = 1;
      end else begin
        start = v.start_at != 0 && cen && en == v.start_at;
        rr = 1'b0;
        if (rbv) begin
          rr = ri != v.rs_w || rc >= v.rs_n;
          rc++;
        end
        if (rr) begin
          if (sb.size() == 0) chk($sformatf("v%0d_rb_unexpected", id), rbw, '1);
          else chk($sformatf("v%0d_rb_word%0d", id, ri), rbw, sb.pop_front());
          if (ri < NW) rb_got[ri] = rbw;
          ri++; rc = 0;
        end
        wv = 1'b0;
        if (wr && wi < NW) begin
          wv = wi != v.vs_w || vc >= v.vs_n;
          vc++;
          win = v.words[wi];
          if (wv) begin wi++; vc = 0; end
        end
        fin = dn > 0 && !busy;
        if (!fin) begin @(posedge clk); #1; end
      end
    end
    wv = 1'b0; rr = 1'b0; start = 1'b0;
    if (!fin) chk($sformatf("v%0d_timeout", id), 1, 0);
    chk($sformatf("v%0d_enable_count", id), en, v.exp_en);
    chk($sformatf("v%0d_readback_count", id), ri, v.exp_rb);
    chk($sformatf("v%0d_done_pulses", id), dn, v.exp_done);
    chk($sformatf("v%0d_enable_in_stall", id), bad_gap, 0);
    if (v.abort_at == 0) begin
      chk($sformatf("v%0d_chain", id), chain, exp_chain);
      chk($sformatf("v%0d_sb_left", id), sb.size(), 0);
    end
  endtask

  initial begin
    vec_t tbl[6];
    logic [W-1:0] ref_w[NW] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'hC0DE0000};
    logic [W-1:0] a2, b2, got2[2];
    logic [63:0] old2;
    int en2, ri2, dn2, wi2;
    bit fin2;
    tbl[0] = mk(2, -1, 0, -1, 0, 0, 0, CL, NW, 1);
    tbl[1] = mk(1, -1, 0, -1, 0, 0, 0, CL, NW, 1);
    tbl[2] = mk(1, 2, 5, 3, 10, 0, 0, CL, NW, 1);
    tbl[3] = mk(1, -1, 0, -1, 0, 0, 0, CL, NW, 1);
    tbl[4] = mk(0, -1, 0, -1, 0, 0, 70, 70, 2, 0);
    tbl[5] = mk(0, -1, 0, -1, 0, 40, 0, CL, NW, 1);
    for (int i = 0; i < NW; i++) begin
      tbl[0].words[i] = ref_w[i];
      tbl[2].words[i] = ref_w[i];
      tbl[3].words[i] = ref_w[i];
      tbl[4].words[i] = $urandom;
      tbl[5].words[i] = $urandom;
    end

    // reset holds with every input trying to provoke activity
    rst = 1'b1; start = 1'b1; wv = 1'b1; win = 32'hFFFFFFFF; pre_val = '1; pre_load = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; pre_load = 1'b0;
      chk($sformatf("reset_hold%0d", c), {busy, done, wr, cdo, cen, cnr, rbv, rbw}, '0);
    end
    rst = 1'b0; start = 1'b0; wv = 1'b0;
    @(posedge clk); #1;
    chk("nreset_release", {cnr, busy, wr}, 3'b100);

    for (int t = 0; t < 6; t++) begin
      run_vec(t, tbl[t]);
      if (t == 0) begin
        chk("full_chain_top", chain[145:114], 32'hDEADBEEF);
        chk("full_chain_low", chain[17:0], 18'h30378);
      end
      if (t == 1) begin
        for (int i = 0; i < 4; i++) chk($sformatf("alt_rb%0d", i), rb_got[i], 32'hAAAAAAAA);
        chk("alt_rb_last", rb_got[4], 32'hAAAA8000);
      end
      if (t == 2) begin
        rb_prev = rb_got;
        chain_prev = chain;
      end
      if (t == 3) begin
        for (int i = 0; i < NW; i++) chk($sformatf("stall_vs_free_rb%0d", i), rb_prev[i], rb_got[i]);
        chk("stall_vs_free_chain", chain_prev, chain);
      end
    end

    // start coinciding with reset must leave the loader idle
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    chk("start_reset_outputs", {busy, done, wr, cdo, cen, cnr, rbv, rbw}, '0);
    @(posedge clk); #1;
    chk("start_reset_idle", {busy, wr, cen, cnr}, 4'b0001);

    // two full words, no padding
    a2 = $urandom; b2 = $urandom;
    old2 = {$urandom, $urandom};
    pre_val2 = old2; pre2 = 1'b1; @(posedge clk); #1; pre2 = 1'b0;
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
    en2 = 0; ri2 = 0; dn2 = 0; wi2 = 0; fin2 = 0;
    for (int cyc = 0; cyc < 500 && !fin2; cyc++) begin
      if (cen2) en2++;
      if (done2) dn2++;
      rr2 = rbv2;
      if (rbv2) begin
        if (ri2 < 2) got2[ri2] = rbw2;
        ri2++;
      end
      wv2 = wr2 && wi2 < 2;
      win2 = wi2 == 0 ? a2 : b2;
      if (wv2) wi2++;
      fin2 = dn2 > 0 && !busy2;
      if (!fin2) begin @(posedge clk); #1; end
    end
    rr2 = 1'b0; wv2 = 1'b0;
    if (!fin2) chk("c64_timeout", 1, 0);
    chk("c64_enable_count", en2, 64);
    chk("c64_readback_count", ri2, 2);
    chk("c64_done_pulses", dn2, 1);
    chk("c64_chain", chain2, {a2, b2});
    chk("c64_rb0", got2[0], old2[63:32]);
    chk("c64_rb1", got2[1], old2[31:0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
